// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_if
//  Purpose  : Bundles the boot byte-stream handshake, the instruction-memory
//             write port and the load status lines of imem_loader.
//  Ports    : in_valid/in_data/in_ready - byte stream in (valid/ready)
//             start                     - restart request from DONE/ERROR
//             wr_en/wr_addr/wr_data     - one-cycle word write to the IMEM
//             cpu_rst/done/err          - CPU hold-off reset and load status
//  Modports : slave  - the loader itself
//             master - the environment (byte source, IMEM, CPU side)
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  start;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  cpu_rst;
    logic                  done;
    logic                  err;

    modport slave (
        input  in_valid, in_data, start,
        output in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
    );

    modport master (
        output in_valid, in_data, start,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Parses a boot byte stream (16-bit word count N, MSB first,
//             then 4*N big-endian instruction bytes, then an XOR checksum
//             byte) and writes each word into the instruction memory.  The
//             CPU is held in reset until a load completes with a good
//             checksum.
//  Ports    : clk - rising-edge clock
//             rst - asynchronous, active-low reset
//             bus - imem_loader_if.slave (stream in, IMEM write, status)
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus
);

    localparam logic [2:0] c_LEN_HI = 3'd0;
    localparam logic [2:0] c_LEN_LO = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_CHECK  = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;
    localparam logic [2:0] c_ERROR  = 3'd5;

    // Largest legal word count: the full memory depth.
    localparam logic [16:0] c_MAX_LEN = 17'd1 << ADDR_WIDTH;

    logic [2:0]            state_q,   state_d;
    logic [15:0]           len_q,     len_d;
    logic [ADDR_WIDTH-1:0] word_q,    word_d;
    logic [1:0]            byte_q,    byte_d;
    logic [23:0]           shift_q,   shift_d;
    logic [7:0]            csum_q,    csum_d;
    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [15:0]           w_len_full;
    logic                  w_last_word;

    assign w_in_ready = (state_q == c_LEN_HI) || (state_q == c_LEN_LO) ||
                        (state_q == c_DATA)   || (state_q == c_CHECK);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_len_full = {len_q[15:8], bus.in_data};

    // word_q is the index of the word being assembled; it is the last one
    // when index + 1 equals N.  Done in 17 bits so N = 2**16 cannot alias.
    assign w_last_word = ({{(17-ADDR_WIDTH){1'b0}}, word_q} + 17'd1) == {1'b0, len_q};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        word_d    = word_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            c_LEN_HI: begin
                if (w_accept) begin
                    len_d   = {bus.in_data, len_q[7:0]};
                    state_d = c_LEN_LO;
                end
            end
            c_LEN_LO: begin
                if (w_accept) begin
                    len_d = w_len_full;
                    if ({1'b0, w_len_full} > c_MAX_LEN) begin
                        state_d = c_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        state_d = c_CHECK;
                    end else begin
                        state_d = c_DATA;
                    end
                end
            end
            c_DATA: begin
                if (w_accept) begin
                    csum_d = csum_q ^ bus.in_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        // Fourth byte completes the word; the strobe is
                        // registered so it appears on the following cycle.
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_q;
                        wr_data_d = {shift_q, bus.in_data};
                        word_d    = word_q + 1'b1;
                        if (w_last_word) begin
                            state_d = c_CHECK;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], bus.in_data};
                    end
                end
            end
            c_CHECK: begin
                if (w_accept) begin
                    state_d = (bus.in_data == csum_q) ? c_DONE : c_ERROR;
                end
            end
            c_DONE, c_ERROR: begin
                if (bus.start) begin
                    state_d = c_LEN_HI;
                    word_d  = '0;
                    byte_d  = 2'd0;
                    shift_d = 24'd0;
                    csum_d  = 8'd0;
                end
            end
            default: begin
                state_d = c_LEN_HI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= c_LEN_HI;
            len_q     <= 16'd0;
            word_q    <= '0;
            byte_q    <= 2'd0;
            shift_q   <= 24'd0;
            csum_q    <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            word_q    <= word_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cpu_rst  = (state_q != c_DONE);
    assign bus.done     = (state_q == c_DONE);
    assign bus.err      = (state_q == c_ERROR);

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, word-address width of the target instruction memory (depth 2**ADDR_WIDTH words).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  byte-stream source has a byte on in_data.
REQ-005 SHALL have port in_data  input  8  boot-stream byte.
REQ-006 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a new load from DONE or ERROR.
REQ-008 SHALL have port wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port wr_addr  output  ADDR_WIDTH  word address of the write.
REQ-010 SHALL have port wr_data  output  32  instruction word to write.
REQ-011 SHALL have port cpu_rst  output  1  active-high reset for the CPU core, held while not loaded.
REQ-012 SHALL have ports done and err  output  1 each  load succeeded / load failed.

Function
REQ-013 SHALL accept a byte only on a rising edge with in_valid=1 and in_ready=1; no other edge changes stream state.
REQ-014 SHALL parse stream: length N (2 bytes, MSB first), then 4*N data bytes, then one checksum byte.
REQ-015 SHALL implement states LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
REQ-016 SHALL drive in_ready=1 in LEN_HI, LEN_LO, DATA, CHECK; in_ready=0 in DONE, ERROR.
REQ-017 LEN_HI: accepted byte -> N[15:8], go LEN_LO.
REQ-018 LEN_LO: accepted byte -> N[7:0]; N > 2**ADDR_WIDTH -> ERROR; N=0 -> CHECK; else -> DATA.
REQ-019 DATA: assemble words big-endian (first byte of word -> wr_data[31:24]); a 2-bit byte counter wraps 3->0.
REQ-020 SHALL assert wr_en for exactly one cycle, registered, in the cycle after the 4th byte of a word is accepted, with wr_addr = word index (first word 0, incrementing by 1) and wr_data the assembled word.
REQ-021 After the 4th byte of word N-1, SHALL move to CHECK (last write strobe coincides with first CHECK cycle).
REQ-022 SHALL keep running checksum = XOR of all data bytes (length bytes excluded), cleared to 0x00 at the start of each load.
REQ-023 CHECK: accepted byte equal to checksum -> DONE, otherwise -> ERROR.
REQ-024 SHALL drive cpu_rst=0 only in DONE; cpu_rst=1 in all other states.
REQ-025 SHALL drive done=1 only in DONE and err=1 only in ERROR.
REQ-026 DONE or ERROR with start=1 -> LEN_HI, clearing word counter, byte counter, checksum; start ignored in other states.
REQ-027 Gaps in in_valid of any length SHALL NOT alter assembled bytes, counters, or state.
REQ-028 wr_addr and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-029 On rst=0, immediately (asynchronously): state LEN_HI, in_ready=1 after release, wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, done=0, err=0, all counters and checksum 0.
REQ-030 Reset mid-load SHALL abandon the partial load; memory contents already written are not cleared; next accepted byte is treated as LEN_HI.

Verification
REQ-031 Stream 00 02 24 08 00 05 00 00 00 0C 25 -> writes (addr 0, 0x24080005), (addr 1, 0x0000000C); then done=1, cpu_rst=0, in_ready=0.
REQ-032 Same stream with checksum 26 -> both writes occur, then err=1, done=0, cpu_rst=1; start pulse -> LEN_HI, err=0, in_ready=1, reload of REQ-031 stream -> done=1.
REQ-033 ADDR_WIDTH=6, stream 00 41 -> err=1 after second byte, no wr_en ever; stream 00 40 accepted (64 writes, addr 0..63).
REQ-034 Stream 00 00 00 -> no wr_en, done=1, cpu_rst=0; stream 00 00 01 -> err=1.
REQ-035 REQ-031 stream with in_valid low for 3 cycles between every byte -> identical writes and result; rst pulsed low after byte 5 then full REQ-031 stream -> outputs reset at once, final result identical to REQ-031.
